// File: rtl/line_axis_bridge.sv
// Bridges the core's cache-line get/put memory port to a beat-wide AXI-stream channel.
// Requests go out as a header beat (plus data beats for writes); read beats are reassembled into lines.
module line_axis_bridge #(
    parameter  int LINE_W     = 512,
    parameter  int BEAT_W     = 128,
    parameter  int ADDR_W     = 26,
    parameter  int ADDR_SHIFT = 2,
    parameter  int MAX_OUTST  = 4,
    localparam int BEATS      = LINE_W / BEAT_W,
    localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    output logic                       getMReq_en,
    input  logic                       getMReq_rdy,
    input  logic [ADDR_W+LINE_W:0]     getMReq_data,
    output logic [BEAT_W-1:0]          req_axis_data,
    output logic                       req_axis_tuser,
    output logic                       req_axis_valid,
    input  logic                       req_axis_ready,
    input  logic [BEAT_W-1:0]          resp_axis_data,
    input  logic                       resp_axis_tuser,
    input  logic                       resp_axis_valid,
    output logic                       resp_axis_ready,
    output logic                       putMResp_en,
    input  logic                       putMResp_rdy,
    output logic [LINE_W-1:0]          putMResp_data,
    output logic [CNT_W-1:0]           outstanding_out,
    output logic                       proto_err_out
);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {Q_IDLE, Q_HDR, Q_DATA} req_state_t;
    typedef enum logic {R_COLLECT, R_FULL} resp_state_t;

    req_state_t                   qstate;
    resp_state_t                  rstate;
    logic [BEATS-1:0][BEAT_W-1:0] line_q;
    logic [BEATS-1:0][BEAT_W-1:0] piece_q;
    logic [IDX_W-1:0]             idx_q, idx_nxt, cnt_q;
    logic                         wr_q;
    logic                         req_wr, read_take, beat_acc, beat_bad;
    logic [ADDR_W-1:0]            req_addr;
    logic [26:0]                  addr_ch;
    logic [BEAT_W-1:0]            hdr;

    assign req_wr     = getMReq_data[ADDR_W+LINE_W];
    assign req_addr   = getMReq_data[LINE_W +: ADDR_W];
    assign getMReq_en = getMReq_rdy && (qstate == Q_IDLE) &&
                        (req_wr || (outstanding_out < CNT_W'(MAX_OUTST)));
    assign read_take  = getMReq_en && !req_wr;
    assign idx_nxt    = idx_q + IDX_W'(1);

    // Header layout: {addr[26:0], len[26:0], write} in the low 55 bits.
    always_comb begin
        addr_ch    = 27'(req_addr) << ADDR_SHIFT;
        hdr        = '0;
        hdr[0]     = req_wr;
        hdr[27:1]  = 27'(BEATS);
        hdr[54:28] = addr_ch;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            qstate         <= Q_IDLE;
            req_axis_valid <= 1'b0;
            req_axis_tuser <= 1'b0;
            req_axis_data  <= '0;
            line_q         <= '0;
            wr_q           <= 1'b0;
            idx_q          <= '0;
        end else begin
            case (qstate)
                Q_IDLE: if (getMReq_en) begin
                    line_q         <= getMReq_data[LINE_W-1:0];
                    wr_q           <= req_wr;
                    req_axis_valid <= 1'b1;
                    req_axis_tuser <= 1'b1;
                    req_axis_data  <= hdr;
                    qstate         <= Q_HDR;
                end
                Q_HDR: if (req_axis_ready) begin
                    if (wr_q) begin
                        req_axis_tuser <= 1'b0;
                        req_axis_data  <= line_q[0];
                        idx_q          <= '0;
                        qstate         <= Q_DATA;
                    end else begin
                        req_axis_valid <= 1'b0;
                        req_axis_tuser <= 1'b0;
                        req_axis_data  <= '0;
                        qstate         <= Q_IDLE;
                    end
                end
                Q_DATA: if (req_axis_ready) begin
                    if (idx_q == LAST) begin
                        req_axis_valid <= 1'b0;
                        req_axis_data  <= '0;
                        qstate         <= Q_IDLE;
                    end else begin
                        req_axis_data  <= line_q[idx_nxt];
                        idx_q          <= idx_nxt;
                    end
                end
                default: qstate <= Q_IDLE;
            endcase
        end
    end

    assign beat_acc      = resp_axis_valid && resp_axis_ready;
    assign beat_bad      = resp_axis_tuser || (outstanding_out == '0);
    assign putMResp_en   = putMResp_rdy && (rstate == R_FULL);
    assign putMResp_data = piece_q;

    // Bad beats are swallowed without advancing cnt so a later clean burst still lines up.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rstate          <= R_COLLECT;
            resp_axis_ready <= 1'b0;
            cnt_q           <= '0;
            piece_q         <= '0;
            proto_err_out   <= 1'b0;
        end else begin
            if (beat_acc && beat_bad)
                proto_err_out <= 1'b1;
            case (rstate)
                R_COLLECT: begin
                    resp_axis_ready <= 1'b1;
                    if (beat_acc && !beat_bad) begin
                        piece_q[cnt_q] <= resp_axis_data;
                        if (cnt_q == LAST) begin
                            cnt_q           <= '0;
                            resp_axis_ready <= 1'b0;
                            rstate          <= R_FULL;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                R_FULL: if (putMResp_en) begin
                    resp_axis_ready <= 1'b1;
                    rstate          <= R_COLLECT;
                end
                default: rstate <= R_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in)
            outstanding_out <= '0;
        else if (read_take && !putMResp_en)
            outstanding_out <= outstanding_out + CNT_W'(1);
        else if (!read_take && putMResp_en && (outstanding_out != '0))
            outstanding_out <= outstanding_out - CNT_W'(1);
    end
endmodule

// File: tb/tb_line_axis_bridge.sv
// Directed bench for line_axis_bridge: stimulus pushes expected beats/lines into queues,
// independent monitors pop and compare whenever the DUT presents a beat or a line.
module tb_line_axis_bridge;
    logic         clk_in, rst_n_in;
    logic         getMReq_en, getMReq_rdy;
    logic [538:0] getMReq_data;
    logic [127:0] req_axis_data;
    logic         req_axis_tuser, req_axis_valid, req_axis_ready;
    logic [127:0] resp_axis_data;
    logic         resp_axis_tuser, resp_axis_valid, resp_axis_ready;
    logic         putMResp_en, putMResp_rdy;
    logic [511:0] putMResp_data;
    logic [2:0]   outstanding_out;
    logic         proto_err_out;

    line_axis_bridge dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .getMReq_en(getMReq_en), .getMReq_rdy(getMReq_rdy), .getMReq_data(getMReq_data),
        .req_axis_data(req_axis_data), .req_axis_tuser(req_axis_tuser),
        .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
        .resp_axis_data(resp_axis_data), .resp_axis_tuser(resp_axis_tuser),
        .resp_axis_valid(resp_axis_valid), .resp_axis_ready(resp_axis_ready),
        .putMResp_en(putMResp_en), .putMResp_rdy(putMResp_rdy), .putMResp_data(putMResp_data),
        .outstanding_out(outstanding_out), .proto_err_out(proto_err_out)
    );

    typedef struct { logic tu; logic [127:0] d; } beat_t;
    beat_t        exp_req[$];
    logic [511:0] exp_resp[$];
    int n_chk = 0, n_fail = 0, req_cnt = 0, ready_mode = 0;

    localparam logic [127:0] H_RD123 = 128'({27'h48C, 27'h4, 1'b0});
    localparam logic [127:0] H_WR1   = 128'({27'h4,   27'h4, 1'b1});
    localparam logic [127:0] H_WR2   = 128'({27'h8,   27'h4, 1'b1});
    localparam logic [127:0] H_RD14  = 128'({27'h50,  27'h4, 1'b0});
    localparam logic [127:0] H_RDMAX = 128'({27'h7FFFFFC, 27'h4, 1'b0});
    localparam logic [127:0] D0 = 128'h000000D0_11111111_22222222_33333333;
    localparam logic [127:0] D1 = 128'h000000D1_44444444_55555555_66666666;
    localparam logic [127:0] D2 = 128'h000000D2_77777777_88888888_99999999;
    localparam logic [127:0] D3 = 128'h000000D3_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    localparam logic [127:0] BA = 128'hAAAA0000_00000000_00000000_0000000A;
    localparam logic [127:0] BB = 128'hBBBB0000_00000000_00000000_0000000B;
    localparam logic [127:0] BC = 128'hCCCC0000_00000000_00000000_0000000C;
    localparam logic [127:0] BD = 128'hDDDD0000_00000000_00000000_0000000D;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timeout or unexpected event", nm);
    endtask

    // Channel back-pressure: 0 = always ready, 1 = random stalls.
    initial begin
        req_axis_ready = 1'b0;
        forever begin
            @(posedge clk_in); #1;
            req_axis_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        logic         stalled;
        logic [128:0] prev;
        beat_t        b;
        logic [511:0] l;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) begin
                stalled = 1'b0;
            end else begin
                if (stalled && req_axis_valid)
                    chk("req_stable", {req_axis_tuser, req_axis_data}, prev);
                stalled = req_axis_valid && !req_axis_ready;
                prev    = {req_axis_tuser, req_axis_data};
                if (req_axis_valid && req_axis_ready) begin
                    if (exp_req.size() == 0) fail("req_unexpected");
                    else begin
                        b = exp_req.pop_front();
                        chk("req_tuser", req_axis_tuser, b.tu);
                        chk("req_data", req_axis_data, b.d);
                    end
                    req_cnt++;
                end
                if (putMResp_en) begin
                    if (exp_resp.size() == 0) fail("resp_unexpected");
                    else begin
                        l = exp_resp.pop_front();
                        chk("resp_line", putMResp_data, l);
                    end
                end
            end
        end
    end

    task automatic issue_req(input logic wr, input logic [25:0] a, input logic [511:0] ln,
                             input logic [127:0] h);
        bit got = 0;
        getMReq_data = {wr, a, ln};
        getMReq_rdy  = 1'b1;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk_in);
            if (getMReq_en) got = 1;
        end
        if (!got) fail("req_take");
        else begin
            exp_req.push_back('{1'b1, h});
            if (wr) for (int i = 0; i < 4; i++) exp_req.push_back('{1'b0, ln[i*128 +: 128]});
        end
        @(posedge clk_in); #1;
        getMReq_rdy = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic tu);
        bit got = 0;
        resp_axis_valid = 1'b1;
        resp_axis_data  = d;
        resp_axis_tuser = tu;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk_in);
            if (resp_axis_ready) got = 1;
        end
        if (!got) fail("resp_accept");
        @(posedge clk_in); #1;
        resp_axis_valid = 1'b0;
        resp_axis_tuser = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk_in);
            if (exp_req.size() == 0 && exp_resp.size() == 0) done = 1;
        end
        if (!done) fail("drain");
        @(posedge clk_in); #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", req_axis_valid, 0);
        chk("rst_req_tuser", req_axis_tuser, 0);
        chk("rst_req_data", req_axis_data, 0);
        chk("rst_getMReq_en", getMReq_en, 0);
        chk("rst_resp_ready", resp_axis_ready, 0);
        chk("rst_putMResp_en", putMResp_en, 0);
        chk("rst_putMResp_data", putMResp_data, 0);
        chk("rst_outstanding", outstanding_out, 0);
        chk("rst_proto_err", proto_err_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int base;
        bit got;
        rst_n_in = 1'b0; getMReq_rdy = 1'b0; getMReq_data = '0;
        resp_axis_valid = 1'b0; resp_axis_tuser = 1'b0; resp_axis_data = '0;
        putMResp_rdy = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs();
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;

        // Single read: header only, outstanding 0 -> 1.
        issue_req(1'b0, 26'h0000123, '0, H_RD123);
        drain();
        chk("outst_after_read", outstanding_out, 1);

        // Line held in FULL while the core is not ready, delivered on first rdy cycle.
        send_beat(BA, 1'b0); send_beat(BB, 1'b0); send_beat(BC, 1'b0); send_beat(BD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            chk("full_resp_ready", resp_axis_ready, 0);
            chk("full_no_en", putMResp_en, 0);
        end
        exp_resp.push_back({BD, BC, BB, BA});
        @(posedge clk_in); #1;
        putMResp_rdy = 1'b1;
        @(negedge clk_in);
        chk("en_first_rdy", putMResp_en, 1);
        drain();
        chk("outst_after_deliver", outstanding_out, 0);

        // Writes: header then D0..D3, without and with random stalls.
        issue_req(1'b1, 26'h1, {D3, D2, D1, D0}, H_WR1);
        drain();
        ready_mode = 1;
        issue_req(1'b1, 26'h2, {D0, D2, D1, D3}, H_WR2);
        drain();
        ready_mode = 0;
        chk("outst_after_writes", outstanding_out, 0);

        // Read limit: four reads go out, fifth blocked until a line is delivered.
        for (int i = 0; i < 4; i++) begin
            logic [127:0] h;
            h = 128'({27'(26'h10 + i) << 2, 27'h4, 1'b0});
            issue_req(1'b0, 26'(26'h10 + i), '0, h);
        end
        drain();
        chk("outst_full", outstanding_out, 4);
        getMReq_data = {1'b0, 26'h14, 512'h0};
        getMReq_rdy  = 1'b1;
        exp_req.push_back('{1'b1, H_RD14});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("fifth_blocked", getMReq_en, 0);
        end
        @(posedge clk_in); #1;
        exp_resp.push_back({BA, BB, BC, BD});
        send_beat(BD, 1'b0); send_beat(BC, 1'b0); send_beat(BB, 1'b0); send_beat(BA, 1'b0);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk_in);
            if (getMReq_en) got = 1;
        end
        if (!got) fail("fifth_take");
        @(posedge clk_in); #1;
        getMReq_rdy = 1'b0;
        drain();
        chk("outst_refill", outstanding_out, 4);

        // tuser=1 beat is dropped and flags a sticky error; following burst still aligns.
        send_beat(D3, 1'b1);
        @(negedge clk_in);
        chk("proto_tuser", proto_err_out, 1);
        @(posedge clk_in); #1;
        exp_resp.push_back({D0, D1, D2, D3});
        send_beat(D3, 1'b0); send_beat(D2, 1'b0); send_beat(D1, 1'b0); send_beat(D0, 1'b0);
        drain();
        chk("proto_sticky", proto_err_out, 1);
        chk("outst_after_err", outstanding_out, 3);

        // Reset after two of four write data beats.
        base = req_cnt;
        issue_req(1'b1, 26'h1, {D3, D2, D1, D0}, H_WR1);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk_in);
            if (req_cnt >= base + 3) got = 1;
        end
        if (!got) fail("partial_write");
        @(posedge clk_in); #1;
        rst_n_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs();
        exp_req.delete();
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;

        // Beat with nothing outstanding is an error; then a clean read header.
        send_beat(BA, 1'b0);
        @(negedge clk_in);
        chk("proto_no_outst", proto_err_out, 1);
        chk("outst_still_zero", outstanding_out, 0);
        @(posedge clk_in); #1;
        issue_req(1'b0, 26'h1FFFFFF, '0, H_RDMAX);
        drain();
        chk("outst_final", outstanding_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
